// File: rtl/dmem_pkg.sv
// Shared types and encodings for the sized data memory: access sizes, the
// init/run state and the response pipeline stage.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } rsp_stage_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for byte/half/word accesses: byte enables,
// replicated store data, extracted and extended load data, alignment error.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel = rdata_raw_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];
    sext     = ~unsigned_i;

    err_o   = 1'b0;
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = '0;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    unique case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sext & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        if (addr_lo_i[0]) begin
          err_o = 1'b1;
        end else begin
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
          rdata_o = {{16{sext & half_sel[15]}}, half_sel};
        end
      end
      SZ_W: begin
        if (addr_lo_i != 2'b00) begin
          err_o = 1'b1;
        end else begin
          be_o    = 4'b1111;
          rdata_o = rdata_raw_i;
        end
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressed word memory with sized loads/stores, a valid/ready request port,
// an RD_LAT-deep response pipeline with backpressure and a post-reset Mem[i] = i sweep.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  rsp_stage_t  stg_q [RD_LAT];
  rsp_stage_t  stg_d [RD_LAT];
  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   raw;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   ld_data;
  logic          err;
  logic          advance;
  logic          accept;
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          unused_addr;

  // Upper address bits are ignored so accesses wrap modulo 4*DEPTH.
  assign idx         = req_addr[AW+1:2];
  assign unused_addr = ^req_addr[31:AW+2];
  assign raw         = mem_q[idx];

  dmem_lane_align u_align (
    .size_i      (req_size),
    .addr_lo_i   (req_addr[1:0]),
    .unsigned_i  (req_unsigned),
    .wdata_i     (req_wdata),
    .rdata_raw_i (raw),
    .be_o        (be),
    .wdata_o     (wdata_sh),
    .rdata_o     (ld_data),
    .err_o       (err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < RD_LAT; i++) begin
        stg_q[i] <= stg_d[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun: ;
    endcase
  end

  // Output / handshake logic.
  always_comb begin
    advance   = rsp_ready | ~stg_q[RD_LAT-1].valid;
    req_ready = (state_q == StRun) & advance;
    accept    = req_valid & req_ready;
    rsp_valid = stg_q[RD_LAT-1].valid;
    rsp_rdata = stg_q[RD_LAT-1].rdata;
    rsp_err   = stg_q[RD_LAT-1].err;
  end

  // The whole pipe moves together; a held output stage freezes every stage behind it.
  always_comb begin
    for (int i = 0; i < RD_LAT; i++) begin
      stg_d[i] = stg_q[i];
    end
    if (advance) begin
      stg_d[0].valid = accept;
      stg_d[0].err   = accept & err;
      stg_d[0].rdata = (accept & ~req_write) ? ld_data : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        stg_d[i] = stg_q[i-1];
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = idx;
    mem_wdata = wdata_sh;
    mem_be    = be;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_widx  = cnt_q;
      mem_wdata = 32'(cnt_q);
      mem_be    = 4'b1111;
    end else if (accept && req_write && !err) begin
      mem_we = 1'b1;
    end
  end

  // Gated by rst_n so a store handshaked on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_be[l]) begin
          mem_q[mem_widx][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Self-checking bench for dmem_sized: directed cases plus random traffic
// against a byte-array reference model with an in-order expectation queue.
module tb_dmem_sized;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_sized #(
    .DEPTH  (256),
    .RD_LAT (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          stalls = 0;
  bit          rnd_rdy = 1'b0;
  exp_t        expq[$];
  logic [7:0]  mb [1024];
  bit          hold = 1'b0;
  logic [31:0] h_rd;
  logic        h_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory as 1024 little-endian bytes, initialised to Mem[i] = i.
  function automatic void model_init();
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 4; j++) begin
        mb[4*i+j] = 8'((i >> (8*j)) & 255);
      end
    end
  endfunction

  function automatic void model_req(input logic w, input logic [1:0] sz, input logic uns,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic er);
    int base;
    int nb;
    base = int'(a % 32'd1024);
    nb   = 1 << sz;
    rd   = '0;
    er   = (sz == 2'd3) || ((nb > 1) && (base % nb != 0));
    if (!er) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mb[base+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) rd[8*i +: 8] = mb[base+i];
        if (!uns && nb < 4 && rd[8*nb-1]) begin
          for (int i = nb; i < 4; i++) rd[8*i +: 8] = 8'hFF;
        end
      end
    end
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int   waited = 0;
    bit   done = 1'b0;
    exp_t e;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    while (!done) begin
      if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (req_ready) begin
        model_req(w, sz, uns, a, wd, e.rd, e.er);
        expq.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
        waited++;
        if (waited > 200) begin
          check("accept_timeout", 32'(waited), 32'd0);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic count_init();
    int n = 0;
    while (!req_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_edges", 32'(n), 32'd256);
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  // Response monitor: in-order scoreboard and hold-stability under backpressure.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_rdata", rsp_rdata, h_rd);
        check("hold_err", 32'(rsp_err), 32'(h_err));
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("rsp_rdata", rsp_rdata, e.rd);
          check("rsp_err", 32'(rsp_err), 32'(e.er));
        end
      end
      hold  = rsp_valid && !rsp_ready;
      h_rd  = rsp_rdata;
      h_err = rsp_err;
    end
  end

  initial begin
    int          s0;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_W;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    model_init();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    count_init();

    // Top word and wrap past the end.
    issue(1'b0, SZ_W, 1'b0, 32'h0000_03FC, '0);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0400, '0);

    // Word store then sub-word loads with extension.
    issue(1'b1, SZ_W, 1'b0, 32'h0000_0010, 32'h80FF_7F01);
    issue(1'b0, SZ_B, 1'b0, 32'h0000_0010, '0);
    issue(1'b0, SZ_B, 1'b0, 32'h0000_0011, '0);
    issue(1'b0, SZ_B, 1'b0, 32'h0000_0012, '0);
    issue(1'b0, SZ_B, 1'b1, 32'h0000_0013, '0);
    issue(1'b0, SZ_H, 1'b0, 32'h0000_0012, '0);
    issue(1'b0, SZ_H, 1'b1, 32'h0000_0012, '0);

    // Byte store into lane 1, half store into upper lanes.
    issue(1'b1, SZ_B, 1'b0, 32'h0000_0021, 32'h1234_56AB);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0020, '0);
    issue(1'b1, SZ_H, 1'b0, 32'h0000_0026, 32'hFFFF_BEEF);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0024, '0);

    // Errors leave memory untouched.
    issue(1'b1, SZ_H, 1'b0, 32'h0000_0031, 32'hFFFF_FFFF);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0030, '0);
    issue(1'b0, 2'd3, 1'b0, 32'h0000_0030, '0);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0032, '0);
    issue(1'b1, SZ_W, 1'b0, 32'h0000_0035, 32'hFFFF_FFFF);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0034, '0);
    drain();

    // Full throughput with the consumer always ready.
    s0 = stalls;
    for (int i = 0; i < 6; i++) issue(1'b0, SZ_W, 1'b0, 32'(4 * i), '0);
    check("throughput_stalls", 32'(stalls - s0), 32'd0);
    drain();

    // Backpressure: three loads fill the pipe, two stalled cycles follow.
    s0 = stalls;
    fork
      begin
        rsp_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) issue(1'b0, SZ_W, 1'b0, 32'(32'h40 + 4 * i), '0);
    check("bp_stalls", 32'(stalls - s0), 32'd2);
    drain();

    // Reset with responses in flight; store on the reset edge is dropped.
    issue(1'b1, SZ_W, 1'b0, 32'h0000_0014, 32'hDEAD_BEEF);
    rsp_ready = 1'b0;
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0014, '0);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0018, '0);
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_W;
    req_addr = 32'h0000_0018; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    check("rst2_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst2_req_ready", 32'(req_ready), 32'd0);
    check("rst2_rsp_rdata", rsp_rdata, 32'd0);
    expq.delete();
    model_init();
    req_valid = 1'b0;
    rst_n = 1'b1;
    count_init();
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0014, '0);
    issue(1'b0, SZ_W, 1'b0, 32'h0000_0018, '0);
    drain();

    // Random traffic with a randomly stalling consumer.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = SZ_W;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      issue(w, sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    rnd_rdy = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised successor to the single-cycle data memory: a word-organised, byte-addressed data memory for the MIPS datapath. It adds byte/half/word loads and stores with sign/zero extension and misalignment detection. It also adds a valid/ready request port, a configurable-latency response pipeline with backpressure, and a post-reset init sweep that loads Mem[i] = i. It sits behind the MEM stage and replaces the fixed-size, always-ready memory.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words; power of two, 2..65536
- RD_LAT, 1, request-accept to response latency in cycles; 1..4

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response when high with rsp_valid
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  request was misaligned or illegal size

## Operation
- States are INIT and RUN. Reset forces INIT, init counter 0, pipeline empty.
- INIT: each cycle writes Mem[cnt] = cnt (zero-extended) and increments cnt. After the write of cnt = DEPTH-1, the block goes to RUN. req_ready is 0 throughout INIT.
- Word index is req_addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH. Lanes are little-endian.
- Error conditions:
  - size 3
  - half access with addr[0] = 1
  - word access with addr[1:0] != 0
- On error the memory is not modified, rsp_err = 1 and rsp_rdata = 0.
- Store: only the addressed lanes are written. A byte store writes wdata[7:0] to lane addr[1:0]. A half store writes wdata[15:0] to lanes {addr[1],1'b0}+1 : +0. A word store writes all four lanes.
- Load: the addressed byte or half is extracted to bit 0 and extended per req_unsigned. A word load returns the word unchanged.
- Each accepted request produces exactly one response, and responses are returned in order.
- Memory is read in the accept cycle, and the result travels down the pipeline. A load accepted the cycle after a store to the same word returns the new data.

## Timing
- Reset values:
  - req_ready = 0
  - rsp_valid = 0
  - rsp_rdata = 0
  - rsp_err = 0
- Init: after the last edge with rst_n = 0, edges 1..DEPTH perform the init writes. req_ready = 1 from edge DEPTH onward.
- Pipeline: RD_LAT stages, each holding a valid bit plus rdata and err.
- Stall rule: advance = rsp_ready or output stage empty. Stages advance only on advance.
- req_ready = (state == RUN) and advance.
- Latency: a request accepted at edge k gives rsp_valid at edge k+RD_LAT when there is no stall. Each stall cycle adds one cycle.
- While rsp_valid = 1 and rsp_ready = 0, rsp_rdata and rsp_err hold stable and no request is accepted.
- Throughput is one request per cycle when rsp_ready stays high.
- Reset mid-operation discards all in-flight responses with no partial output. The memory is reinitialised by a new INIT sweep. A store accepted on the same edge that rst_n is sampled low is not performed.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2
  - the state encoding INIT / RUN
  - the response-stage struct {valid, rdata, err}
- Sub-module dmem_lane_align is combinational. It takes size, addr[1:0], unsigned, wdata and the raw word. It produces the 4-bit byte-enable mask, the lane-shifted write data, the extended load data and err.
- Top level contains the memory array, the INIT FSM and counter, and the RD_LAT pipeline.

## Test plan
- Reset, then count cycles, with DEPTH = 256 -> req_ready rises exactly 256 edges after reset release. A word load of addr 0x3FC returns 0x000000FF; addr 0x400 wraps to word 0 and returns 0.
- Word store 0x80FF7F01 at 0x10, then byte loads:
  - 0x10 signed -> 0x00000001
  - 0x11 signed -> 0x0000007F
  - 0x12 signed -> 0xFFFFFFFF
  - 0x13 unsigned -> 0x00000080
  - half load 0x12 signed -> 0xFFFF80FF
- Byte store 0xAB at 0x21, then a word load of 0x20 -> 0x0000AB08 (init value 8 with lane 1 replaced).
- Errors: half store at 0x31 -> rsp_err = 1 and a following word load of 0x30 returns 0x0000000C. size 3 and a word load at 0x32 -> rsp_err = 1, rdata 0.
- RD_LAT = 3, back-to-back loads with rsp_ready held low for 5 cycles -> req_ready drops once the pipeline fills. The output stays stable, and all responses arrive in order with none lost or duplicated.
- Assert rst_n low with 2 responses in flight -> rsp_valid = 0 on the next edge. INIT restarts, and a prior store to word 5 reads back 5 after init.
